// File: rtl/ins_cache_ctrl.sv
// Instruction cache controller: holds one ISA_DEPTH-word block of the program,
// refills it from instruction memory on a miss and serves hits to AP_ctrl.
//
// Memory read handshake: while mem_rd_req is high, mem_rd_addr is held stable.
// Each cycle with mem_rd_valid high transfers exactly one word for the current
// mem_rd_addr. The address then advances to the next word. After the last word
// of the block, mem_rd_req drops. mem_rd_valid outside a refill is ignored.
module ins_cache_ctrl #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  input  logic                      ins_req,
  output logic                      mem_rd_req,
  output logic [ADDR_WIDTH_MEM-1:0] mem_rd_addr,
  input  logic                      mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [DATA_WIDTH-1:0]     ins_out,
  output logic                      ins_out_valid,
  output logic                      ins_cache_rdy,
  output logic [3:0]                st_cur_ins_cache,
  output logic [9:0]                load_times
);

  localparam int LOG2 = $clog2(ISA_DEPTH);

  // Reject parameter sets the block-index arithmetic cannot handle.
  if (ISA_DEPTH < 2 || (ISA_DEPTH & (ISA_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ISA_DEPTH must be a power of two >= 2");
  end
  if (TOTAL_ISA_DEPTH < ISA_DEPTH) begin : g_bad_total
    $error("TOTAL_ISA_DEPTH must be at least ISA_DEPTH");
  end

  typedef enum logic [3:0] {
    START    = 4'd1,
    LOAD_INS = 4'd2,
    SENT_INS = 4'd3
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH_MEM-1:0] base_q;
  logic [LOG2-1:0]           fill_q;
  logic [9:0]                load_times_q;
  logic                      mem_rd_req_q;
  logic [ADDR_WIDTH_MEM-1:0] mem_rd_addr_q;
  logic [DATA_WIDTH-1:0]     ins_out_q;
  logic                      ins_out_valid_q;
  logic                      ins_cache_rdy_q;
  logic [DATA_WIDTH-1:0]     mem_q [ISA_DEPTH];

  logic [ADDR_WIDTH_MEM-1:0] blk_base_d;
  logic [LOG2-1:0]           fill_d;
  logic [9:0]                load_times_d;
  logic                      same_blk;
  logic                      hit_cur;
  logic                      hit_after_fill;
  logic                      last_word;

  // Block-level address arithmetic and hit detection.
  always_comb begin
    blk_base_d     = {addr_ins[ADDR_WIDTH_MEM-1:LOG2], {LOG2{1'b0}}};
    fill_d         = fill_q + LOG2'(1);
    load_times_d   = 10'(base_q >> LOG2) + 10'd1;
    same_blk       = (addr_ins[ADDR_WIDTH_MEM-1:LOG2] == base_q[ADDR_WIDTH_MEM-1:LOG2]);
    hit_cur        = (load_times_q != 10'd0) && same_blk;
    hit_after_fill = (load_times_d != 10'd0) && same_blk;
    last_word      = (fill_q == LOG2'(ISA_DEPTH - 1));
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= START;
      base_q          <= '0;
      fill_q          <= '0;
      load_times_q    <= '0;
      mem_rd_req_q    <= 1'b0;
      mem_rd_addr_q   <= '0;
      ins_out_q       <= '0;
      ins_out_valid_q <= 1'b0;
      ins_cache_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          ins_out_valid_q <= 1'b0;
          if (!hit_cur) begin
            // Any miss refills, with or without a pending request.
            state_q         <= LOAD_INS;
            base_q          <= blk_base_d;
            fill_q          <= '0;
            load_times_q    <= '0;
            mem_rd_req_q    <= 1'b1;
            mem_rd_addr_q   <= blk_base_d;
            ins_cache_rdy_q <= 1'b0;
          end else if (ins_req) begin
            state_q         <= SENT_INS;
            ins_out_q       <= mem_q[addr_ins[LOG2-1:0]];
            ins_out_valid_q <= 1'b1;
            ins_cache_rdy_q <= 1'b0;
          end else begin
            ins_cache_rdy_q <= 1'b1;
          end
        end
        LOAD_INS: begin
          if (mem_rd_valid) begin
            fill_q <= fill_d;
            if (last_word) begin
              state_q         <= START;
              load_times_q    <= load_times_d;
              mem_rd_req_q    <= 1'b0;
              ins_cache_rdy_q <= hit_after_fill;
            end else begin
              // base is block-aligned, so OR-ing the offset is an add.
              mem_rd_addr_q <= base_q | ADDR_WIDTH_MEM'(fill_d);
            end
          end
        end
        SENT_INS: begin
          state_q         <= START;
          ins_out_valid_q <= 1'b0;
          ins_cache_rdy_q <= hit_cur;
        end
        default: begin
          state_q         <= START;
          ins_out_valid_q <= 1'b0;
          ins_cache_rdy_q <= 1'b0;
          mem_rd_req_q    <= 1'b0;
        end
      endcase
    end
  end

  // Block storage, written only by refill data.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_INS && mem_rd_valid) begin
      mem_q[fill_q] <= mem_rd_data;
    end
  end

  assign mem_rd_req       = mem_rd_req_q;
  assign mem_rd_addr      = mem_rd_addr_q;
  assign ins_out          = ins_out_q;
  assign ins_out_valid    = ins_out_valid_q;
  assign ins_cache_rdy    = ins_cache_rdy_q;
  assign st_cur_ins_cache = state_q;
  assign load_times       = load_times_q;

endmodule

// File: tb/tb_ins_cache_ctrl.sv
// Testbench for ins_cache_ctrl: directed sequence with randomized memory
// stalls and fetch addresses, checked against a block-level cache model.
module tb_ins_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr_ins;
  logic        ins_req;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [31:0] ins_out;
  logic        ins_out_valid;
  logic        ins_cache_rdy;
  logic [3:0]  st_cur_ins_cache;
  logic [9:0]  load_times;

  int total = 0;
  int bad   = 0;

  // Reference model: which block is resident and what its words hold.
  int          model_blk = -1;
  logic [31:0] model_mem [64];
  logic [15:0] exp_q [$];

  ins_cache_ctrl #(
    .ADDR_WIDTH_MEM(16), .DATA_WIDTH(32), .ISA_DEPTH(64), .TOTAL_ISA_DEPTH(128)
  ) dut (
    .clk(clk), .rst(rst_n), .addr_ins(addr_ins), .ins_req(ins_req),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .ins_out(ins_out), .ins_out_valid(ins_out_valid),
    .ins_cache_rdy(ins_cache_rdy), .st_cur_ins_cache(st_cur_ins_cache),
    .load_times(load_times)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  function automatic logic model_hit(input logic [15:0] a);
    return (model_blk >= 0) && (int'(a >> 6) == model_blk);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_state", 32'(st_cur_ins_cache), 32'd1);
    chk("rst_load_times", 32'(load_times), 32'd0);
    chk("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    chk("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_ins_out", ins_out, 32'd0);
    chk("rst_ins_out_valid", 32'(ins_out_valid), 32'd0);
    chk("rst_ins_cache_rdy", 32'(ins_cache_rdy), 32'd0);
  endtask

  // Acts as instruction memory for one refill. Starts and ends on a negedge
  // with the DUT already in LOAD_INS. chg_at changes addr_ins mid-refill,
  // abort_at asserts reset before that word is delivered.
  task automatic refill(input logic [15:0] base, input int chg_at,
                        input logic [15:0] chg_addr, input int abort_at);
    logic [15:0] ea;
    int          stall;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 16'(i));
    model_blk = -1;
    chk("load_state", 32'(st_cur_ins_cache), 32'd2);
    chk("load_lt_zero", 32'(load_times), 32'd0);
    chk("load_rdy_zero", 32'(ins_cache_rdy), 32'd0);
    for (int i = 0; i < 64; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        return;
      end
      if (i == chg_at) addr_ins = chg_addr;
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      ea = exp_q.pop_front();
      chk("rd_req", 32'(mem_rd_req), 32'd1);
      chk("rd_addr", 32'(mem_rd_addr), 32'(ea));
      mem_rd_valid = 1'b1;
      mem_rd_data  = word_of(ea);
      model_mem[i] = word_of(ea);
      @(negedge clk);
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
    end
    model_blk = int'(base >> 6);
    chk("fill_state", 32'(st_cur_ins_cache), 32'd1);
    chk("fill_lt", 32'(load_times), 32'((model_blk + 1) & 32'h3FF));
    chk("fill_req_low", 32'(mem_rd_req), 32'd0);
    chk("fill_rdy", 32'(ins_cache_rdy), 32'(model_hit(addr_ins)));
  endtask

  // Fetch one resident instruction and check the single-cycle delivery.
  task automatic serve(input logic [15:0] a);
    logic [31:0] ew;
    ew = model_mem[a[5:0]];
    addr_ins = a;
    ins_req  = 1'b1;
    @(negedge clk);
    chk("sent_state", 32'(st_cur_ins_cache), 32'd3);
    chk("sent_valid", 32'(ins_out_valid), 32'd1);
    chk("sent_ins", ins_out, ew);
    chk("sent_rdy", 32'(ins_cache_rdy), 32'd0);
    ins_req = 1'b0;
    @(negedge clk);
    chk("after_state", 32'(st_cur_ins_cache), 32'd1);
    chk("after_valid", 32'(ins_out_valid), 32'd0);
    chk("after_ins_hold", ins_out, ew);
    chk("after_rdy", 32'(ins_cache_rdy), 32'(model_hit(a)));
  endtask

  initial begin
    rst_n = 1'b0; addr_ins = 16'd0; ins_req = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_data = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();

    // Cold start: address 0 misses and block 0 loads.
    rst_n = 1'b1;
    @(negedge clk);
    refill(16'd0, -1, 16'd0, -1);
    serve(16'd5);
    for (int k = 0; k < 6; k++) serve(16'($urandom_range(0, 63)));

    // Stray read data while idle must not disturb anything.
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    chk("stray_state", 32'(st_cur_ins_cache), 32'd1);
    chk("stray_lt", 32'(load_times), 32'd1);
    serve(16'd0);

    // Crossing the block edge 63 -> 64.
    addr_ins = 16'd63;
    @(negedge clk);
    chk("edge63_rdy", 32'(ins_cache_rdy), 32'd1);
    addr_ins = 16'd64;
    @(negedge clk);
    refill(16'd64, -1, 16'd0, -1);
    for (int k = 0; k < 4; k++) serve(16'd64 + 16'($urandom_range(0, 63)));

    // Interrupt vector outside the program region.
    addr_ins = 16'h8000;
    @(negedge clk);
    refill(16'h8000, -1, 16'd0, -1);
    chk("vec_lt_literal", 32'(load_times), 32'h201);
    for (int k = 0; k < 3; k++) serve(16'h8000 + 16'($urandom_range(0, 63)));

    // Request arriving together with a miss is served after the refill.
    addr_ins = 16'd3; ins_req = 1'b1;
    @(negedge clk);
    refill(16'd0, -1, 16'd0, -1);
    @(negedge clk);
    chk("late_sent_state", 32'(st_cur_ins_cache), 32'd3);
    chk("late_sent_valid", 32'(ins_out_valid), 32'd1);
    chk("late_sent_ins", ins_out, model_mem[3]);
    ins_req = 1'b0;
    @(negedge clk);

    // Address moves during a refill; the refill completes, then re-evaluates.
    addr_ins = 16'd130;
    @(negedge clk);
    refill(16'd128, 30, 16'd75, -1);
    @(negedge clk);
    refill(16'd64, -1, 16'd0, -1);
    serve(16'd75);

    // Reset in the middle of a refill, with stray data around the release.
    addr_ins = 16'd200;
    @(negedge clk);
    refill(16'd192, -1, 16'd0, 10);
    mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD0BAD0;
    @(negedge clk);
    chk("in_rst_req", 32'(mem_rd_req), 32'd0);
    chk("in_rst_state", 32'(st_cur_ins_cache), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    refill(16'd192, -1, 16'd0, -1);
    serve(16'd200);
    serve(16'd192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_cache_ctrl.md
INS_CACHE_CTRL -- requirements
Module: ins_cache_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH_MEM, default 16, width of instruction and memory addresses.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter ISA_DEPTH, default 64, words per cache block; a power of two.
REQ-004 Parameter TOTAL_ISA_DEPTH, default 128, size of the program region in words.
REQ-005 The block has one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1, system clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-low reset.
REQ-008 Port addr_ins, input, ADDR_WIDTH_MEM, current fetch address from program_counter.
REQ-009 Port ins_req, input, 1, AP_ctrl requests the instruction at addr_ins.
REQ-010 Port mem_rd_req, output, 1, read request to instruction memory.
REQ-011 Port mem_rd_addr, output, ADDR_WIDTH_MEM, read address to memory.
REQ-012 Port mem_rd_valid, input, 1, mem_rd_data valid, one word per assertion.
REQ-013 Port mem_rd_data, input, DATA_WIDTH, returned memory word.
REQ-014 Port ins_out, output, DATA_WIDTH, instruction delivered to AP_ctrl.
REQ-015 Port ins_out_valid, output, 1, one-cycle pulse qualifying ins_out.
REQ-016 Port ins_cache_rdy, output, 1, addr_ins hits the resident block and the controller is idle.
REQ-017 Port st_cur_ins_cache, output, 4, current state code.
REQ-018 Port load_times, output, 10, index+1 of the resident block; 0 = none resident.

Function
REQ-019 Storage: ISA_DEPTH x DATA_WIDTH array plus a base register; the resident window is [ISA_DEPTH*(load_times-1), ISA_DEPTH*load_times).
REQ-020 Hit: load_times != 0 and addr_ins inside the window; otherwise miss.
REQ-021 States: START=4'd1 (idle/serve), LOAD_INS=4'd2 (refill), SENT_INS=4'd3 (deliver); st_cur_ins_cache shows the current state.
REQ-022 START, miss: next cycle enters LOAD_INS with base = addr_ins with its low log2(ISA_DEPTH) bits cleared and fill counter = 0; the miss triggers even without ins_req.
REQ-023 START, hit and ins_req=1: next cycle enters SENT_INS, ins_out = array[addr_ins mod ISA_DEPTH], ins_out_valid=1.
REQ-024 SENT_INS lasts exactly one cycle, then START; ins_out_valid=0 in every other state; ins_out holds its last value.
REQ-025 LOAD_INS: mem_rd_req=1 and mem_rd_addr = base + fill counter, held stable until mem_rd_valid.
REQ-026 Each mem_rd_valid in LOAD_INS writes mem_rd_data to array[fill counter], then increments the counter.
REQ-027 The write of word ISA_DEPTH-1 sets load_times = base/ISA_DEPTH + 1 and enters START on the next cycle, with mem_rd_req=0.
REQ-028 mem_rd_valid outside LOAD_INS is ignored.
REQ-029 load_times = 0 throughout a refill; the previous block is invalid once refill begins.
REQ-030 A miss with addr_ins >= TOTAL_ISA_DEPTH (e.g. interrupt vector, MSB set) refills normally; load_times is truncated to 10 bits.
REQ-031 ins_cache_rdy is registered and equals 1 only in START with a hit on the current addr_ins; it is 0 in LOAD_INS and SENT_INS.
REQ-032 If ins_req and a miss occur together, the refill runs first; the instruction is served after return to START if ins_req is still high.
REQ-033 An addr_ins change during LOAD_INS does not abort the refill; the hit check is re-evaluated in START.

Reset
REQ-034 rst=0 immediately forces: state START, load_times=0, fill counter 0, mem_rd_req=0, mem_rd_addr=0, ins_out=0, ins_out_valid=0, ins_cache_rdy=0; array contents don't-care.
REQ-035 Reset mid-refill aborts the transfer; mem_rd_valid arriving after reset is ignored.
REQ-036 After release, the controller evaluates addr_ins in START on the first clock edge.

Verification
REQ-037 Reset release with addr_ins=0 -> LOAD_INS, 64 reads at addresses 0..63; then load_times=1, START, ins_cache_rdy=1.
REQ-038 load_times=1, addr_ins=5, ins_req=1 -> one cycle later SENT_INS, ins_out = word from address 5, single-cycle ins_out_valid.
REQ-039 addr_ins steps 63 to 64 -> ins_cache_rdy=0, refill of 64..127 with mem_rd_valid stalls of 0-3 cycles; load_times=2.
REQ-040 addr_ins=16'h8000 while load_times=2 -> refill from 16'h8000; load_times=10'h201 truncated (0x200+1).
REQ-041 rst=0 after 10 refill words -> all outputs reset at once, mem_rd_req=0; stray mem_rd_valid ignored; a fresh refill starts from word 0.
REQ-042 mem_rd_valid pulsed in START -> no array write, load_times and state unchanged.
